// File: rtl/fetch_stage.sv
// Instruction fetch: issues PC to imem, waits for a variable-latency ack, loads IF/ID.
// Latency: ISSUE->earliest ack 1 cycle, 1 instr per 2 cycles peak. Stall parks data in a hold buffer.
// Optional FETCH_PERF_EN adds FetchCount/WaitCycles counters.
module fetch_stage #(
   parameter int WIDTH       = 32,
   parameter int INSTR_BYTES = 4
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] PCNext,
   output logic             PCWrite,
   output logic             ImemReq,
   output logic [WIDTH-1:0] ImemAddr,
   input  logic             ImemAck,
   input  logic [WIDTH-1:0] ImemData,
   input  logic             Stall,
   input  logic             Flush,
   input  logic [WIDTH-1:0] BranchTarget,
   output logic [WIDTH-1:0] InstrOut,
   output logic [WIDTH-1:0] PCPlus4Out,
`ifdef FETCH_PERF_EN
   output logic [31:0]      FetchCount,
   output logic [31:0]      WaitCycles,
`endif
   output logic             ValidOut
);

   typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD} state_t;

   state_t           state_q, state_d;
   logic             kill_q, kill_d;
   logic [WIDTH-1:0] redir_q, redir_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [WIDTH-1:0] instr_q, instr_d;
   logic [WIDTH-1:0] pc4_q, pc4_d;
   logic             valid_q, valid_d;

   logic [WIDTH-1:0] pc_plus;
   logic             pc_write;
   logic [WIDTH-1:0] pc_next;
   logic             load_mem;
   logic             load_hold;
   logic             capture;

   assign pc_plus = PC + WIDTH'(INSTR_BYTES);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= S_ISSUE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_ISSUE: state_d = Flush ? S_ISSUE : S_WAIT;
         S_WAIT: begin
            if (ImemAck) begin
               if (Flush || kill_q) state_d = S_ISSUE;
               else if (Stall)      state_d = S_HOLD;
               else                 state_d = S_ISSUE;
            end
         end
         S_HOLD: if (Flush || !Stall) state_d = S_ISSUE;
         default: state_d = S_ISSUE;
      endcase
   end

   always_comb begin
      pc_write  = 1'b0;
      pc_next   = pc_plus;
      load_mem  = 1'b0;
      load_hold = 1'b0;
      capture   = 1'b0;
      case (state_q)
         S_ISSUE: begin
            if (Flush) begin
               pc_write = 1'b1;
               pc_next  = BranchTarget;
            end
         end
         S_WAIT: begin
            if (ImemAck) begin
               if (Flush) begin
                  pc_write = 1'b1;
                  pc_next  = BranchTarget;
               end else if (kill_q) begin
                  pc_write = 1'b1;
                  pc_next  = redir_q;
               end else if (!Stall) begin
                  pc_write = 1'b1;
                  load_mem = 1'b1;
               end else begin
                  capture = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (Flush) begin
               pc_write = 1'b1;
               pc_next  = BranchTarget;
            end else if (!Stall) begin
               pc_write  = 1'b1;
               load_hold = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Gating with Reset_n makes the request and PC enable drop the instant reset asserts.
   assign ImemReq  = Reset_n && (state_q != S_HOLD);
   assign ImemAddr = PC;
   assign PCWrite  = Reset_n && pc_write;
   assign PCNext   = pc_next;

   always_comb begin
      kill_d  = kill_q;
      redir_d = redir_q;
      hold_d  = hold_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (state_q == S_WAIT) begin
         if (ImemAck)    kill_d = 1'b0;
         else if (Flush) begin
            kill_d  = 1'b1;
            redir_d = BranchTarget;
         end
      end
      if (capture)                        hold_d = ImemData;
      else if (state_q == S_HOLD && Flush) hold_d = '0;
      if (load_mem || load_hold) begin
         instr_d = load_mem ? ImemData : hold_q;
         pc4_d   = pc_plus;
         valid_d = 1'b1;
      end else if (Flush || !Stall) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         kill_q  <= 1'b0;
         redir_q <= '0;
         hold_q  <= '0;
         instr_q <= '0;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         kill_q  <= kill_d;
         redir_q <= redir_d;
         hold_q  <= hold_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign InstrOut   = instr_q;
   assign PCPlus4Out = pc4_q;
   assign ValidOut   = valid_q;

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] wait_cnt_q, wait_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q + {31'd0, (load_mem || load_hold)};
      wait_cnt_d  = wait_cnt_q + {31'd0, (state_q == S_WAIT && !ImemAck)};
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         fetch_cnt_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   assign FetchCount = fetch_cnt_q;
   assign WaitCycles = wait_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: imem model with random latency, scoreboard of the expected
// instruction stream (sequential +4, redirected by Flush) checked whenever decode consumes.
module tb_fetch_stage;

   logic        Clk;
   logic        Reset_n;
   logic [31:0] PC;
   logic [31:0] PCNext;
   logic        PCWrite;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemAck;
   logic [31:0] ImemData;
   logic        Stall;
   logic        Flush;
   logic [31:0] BranchTarget;
   logic [31:0] InstrOut;
   logic [31:0] PCPlus4Out;
   logic        ValidOut;
`ifdef FETCH_PERF_EN
   logic [31:0] FetchCount;
   logic [31:0] WaitCycles;
`endif

   fetch_stage #(.WIDTH(32), .INSTR_BYTES(4)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .PC(PC), .PCNext(PCNext), .PCWrite(PCWrite),
      .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemData(ImemData),
      .Stall(Stall), .Flush(Flush), .BranchTarget(BranchTarget),
      .InstrOut(InstrOut), .PCPlus4Out(PCPlus4Out),
`ifdef FETCH_PERF_EN
      .FetchCount(FetchCount), .WaitCycles(WaitCycles),
`endif
      .ValidOut(ValidOut)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Environment state: memory transaction counter and chosen latency.
   int   cnt, lat, fixed_lat, stall_pct, flush_pct;
   bit   mon_en = 1'b0;
   bit   pending, prev_flush;
   logic [31:0] last_tgt;
   int   since_pcw;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick_lat();
      if (fixed_lat > 0) return fixed_lat;
      return ($urandom_range(0, 9) == 0) ? 6 : int'($urandom_range(1, 4));
   endfunction

   function automatic logic [31:0] pick_tgt();
      case ($urandom_range(0, 5))
         0:       return 32'hFFFF_FFFC;
         1:       return 32'h0000_0040;
         default: return $urandom & 32'h0000_03FC;
      endcase
   endfunction

   // One clock of environment: PC register, imem responder, random Stall/Flush.
   task automatic cycle();
      logic req_s, pcw_s;
      logic [31:0] pcn_s;
      @(negedge Clk);
      req_s = ImemReq;
      pcw_s = PCWrite;
      pcn_s = PCNext;
      @(posedge Clk);
      #1;
      if (pcw_s) PC = pcn_s;
      if (!req_s || pcw_s) cnt = 0;
      else                 cnt++;
      if (cnt == 0) lat = pick_lat();
      ImemAck      = (cnt == lat);
      ImemData     = ImemAck ? memf(PC) : $urandom;
      Stall        = ($urandom_range(0, 99) < stall_pct);
      Flush        = ($urandom_range(0, 99) < flush_pct);
      BranchTarget = pick_tgt();
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic do_reset(input logic [31:0] rv);
      mon_en       = 1'b0;
      Reset_n      = 1'b0;
      PC           = rv;
      ImemAck      = 1'b0;
      ImemData     = '0;
      Stall        = 1'b0;
      Flush        = 1'b0;
      BranchTarget = '0;
      cnt          = 0;
      lat          = pick_lat();
      #1;
      chk("rst_imemreq", {31'd0, ImemReq}, 32'd0);
      chk("rst_pcwrite", {31'd0, PCWrite}, 32'd0);
      @(posedge Clk);
      #1;
      chk("rst_valid", {31'd0, ValidOut}, 32'd0);
      chk("rst_instr", InstrOut, 32'd0);
      chk("rst_pc4", PCPlus4Out, 32'd0);
      exp_q.delete();
      exp_q.push_back('{instr: memf(rv), pc4: rv + 32'd4});
      pending    = 1'b0;
      prev_flush = 1'b0;
      since_pcw  = 0;
      Reset_n    = 1'b1;
      mon_en     = 1'b1;
   endtask

   // Monitor: checks address, PC updates and every consumed IF/ID entry against the stream model.
   always @(negedge Clk) begin
      if (Reset_n && mon_en) begin
         exp_t e;
         if (ImemReq) chk("imem_addr", ImemAddr, PC);
         if (prev_flush) chk("valid_after_flush", {31'd0, ValidOut}, 32'd0);
         if (Flush) begin
            last_tgt = BranchTarget;
            pending  = 1'b1;
         end
         if (PCWrite) begin
            chk("pcnext", PCNext, pending ? last_tgt : PC + 32'd4);
            pending   = 1'b0;
            since_pcw = 0;
         end else begin
            since_pcw++;
            if (since_pcw > 100) begin
               vectors++;
               miscompares++;
               $display("FAIL watchdog: no PCWrite for %0d cycles, required at most 100", since_pcw);
               since_pcw = 0;
            end
         end
         if (ValidOut && !Stall && !Flush) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL consume: got pc4 %h, expected no valid entry", PCPlus4Out);
            end else begin
               e = exp_q.pop_front();
               chk("instr", InstrOut, e.instr);
               chk("pcplus4", PCPlus4Out, e.pc4);
               exp_q.push_back('{instr: memf(e.pc4), pc4: e.pc4 + 32'd4});
            end
         end
         if (Flush) begin
            exp_q.delete();
            exp_q.push_back('{instr: memf(BranchTarget), pc4: BranchTarget + 32'd4});
         end
         prev_flush = Flush;
      end
   end

   initial begin
      bit found;
      Reset_n   = 1'b1;
      fixed_lat = 1;
      stall_pct = 0;
      flush_pct = 0;
      #1;
      do_reset(32'd0);
      run(12);
      fixed_lat = 5;
      run(30);
      fixed_lat = 0;
      stall_pct = 40;
      run(200);
      flush_pct = 6;
      run(3000);
      stall_pct = 50;
      flush_pct = 15;
      run(1000);

      // Reset asserted while a request is outstanding.
      stall_pct = 0;
      flush_pct = 0;
      fixed_lat = 6;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         if (ImemReq && cnt >= 1 && !ImemAck) found = 1'b1;
      end
      chk("reach_wait", {31'd0, found}, 32'd1);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("async_req_drop", {31'd0, ImemReq}, 32'd0);
      chk("async_pcw_drop", {31'd0, PCWrite}, 32'd0);

      // Sequential fetch across the top of the address space.
      fixed_lat = 0;
      do_reset(32'hFFFF_FFF4);
      stall_pct = 20;
      run(60);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
